// File: rtl/uart_rx_bridge_pkg.sv
// Shared definitions for the UART receive bridge: deserializer state
// encodings, frame constants and small helpers.
package uart_rx_bridge_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned BAUD_DIV_MIN   = 4;

  // True when idx addresses the final data bit of a frame.
  function automatic logic is_last_bit(input logic [2:0] idx);
    return idx == 3'(UART_DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with a first-word-fall-through head.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   push, din      write request and byte (ignored when full unless popping)
//   pop            read request (ignored when empty)
//   dout           head byte, 0 when empty
//   full, empty    occupancy flags
//   count          entries held, derived from the pointers
module uart_rx_fifo
  import uart_rx_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] din,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      full,
  output logic                      empty,
  output logic [CNT_W-1:0]          count
);

  localparam int unsigned AW = CNT_W - 1;

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [CNT_W-1:0]          wr_ptr;
  logic [CNT_W-1:0]          rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_bridge.sv
// UART 8N1 receiver feeding a host-drained byte FIFO.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   rx             serial line, idle high, asynchronous to clock
//   baud_div       clocks per bit, values below 4 behave as 4
//   rd_en, err_clr host pop request / sticky flag clear
//   rd_data        FIFO head byte (first-word-fall-through)
//   rd_valid       FIFO not empty
//   fifo_count     bytes held
//   frame_err      sticky: stop bit sampled low
//   overrun        sticky: byte dropped on a full FIFO
//   irq            rd_valid | frame_err | overrun
module uart_rx_bridge
  import uart_rx_bridge_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx,
  input  logic [DIV_W-1:0]          baud_div,
  input  logic                      rd_en,
  input  logic                      err_clr,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      rd_valid,
  output logic [CNT_W-1:0]          fifo_count,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      irq
);

  rx_state_e state;
  rx_state_e state_nxt;

  logic                      rx_meta;
  logic                      rx_sync;
  logic                      rx_prev;
  logic [1:0]                sync_vld;
  logic                      start_edge;

  logic [DIV_W-1:0]          div_q;
  logic [DIV_W-1:0]          bit_cnt;
  logic [DIV_W-1:0]          eff_div;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      tick;

  logic                      load_start;
  logic                      load_bit;
  logic                      sample_data;
  logic                      push;
  logic                      frame_set;
  logic                      overrun_set;

  logic                      fifo_full;
  logic                      fifo_empty;

  // Two-flop synchronizer. The reset value of 1 is not a real observation
  // of the line, so rx_prev only follows rx_sync once genuine samples have
  // reached the second flop; a line held low across reset release is
  // therefore never seen as a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      sync_vld <= '0;
      rx_prev  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      sync_vld <= {sync_vld[0], 1'b1};
      rx_prev  <= sync_vld[1] & rx_sync;
    end
  end

  assign start_edge = sync_vld[1] & rx_prev & ~rx_sync;

  assign eff_div = (baud_div < DIV_W'(BAUD_DIV_MIN)) ? DIV_W'(BAUD_DIV_MIN) : baud_div;

  // Every sample point is reached when the down-counter reads 1.
  assign tick = (bit_cnt == DIV_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RX_IDLE:  if (start_edge) state_nxt = RX_START;
      RX_START: if (tick)       state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && is_last_bit(bit_idx)) state_nxt = RX_STOP;
      RX_STOP:  if (tick)       state_nxt = RX_IDLE;
      default:                  state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    load_start  = 1'b0;
    load_bit    = 1'b0;
    sample_data = 1'b0;
    push        = 1'b0;
    frame_set   = 1'b0;
    unique case (state)
      RX_IDLE:  load_start = start_edge;
      RX_START: load_bit   = tick & ~rx_sync;
      RX_DATA: begin
        load_bit    = tick;
        sample_data = tick;
      end
      RX_STOP: begin
        push      = tick & rx_sync;
        frame_set = tick & ~rx_sync;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (load_start) begin
        div_q   <= eff_div;
        bit_cnt <= eff_div >> 1;
        bit_idx <= '0;
      end else if (load_bit) begin
        bit_cnt <= div_q;
      end else if (state != RX_IDLE) begin
        bit_cnt <= bit_cnt - DIV_W'(1);
      end
      if (sample_data) begin
        shift[bit_idx] <= rx_sync;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (shift),
    .pop   (rd_en),
    .dout  (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A full FIFO only drops the byte when the host is not popping that cycle.
  assign overrun_set = push & fifo_full & ~rd_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set   | (frame_err & ~err_clr);
      overrun   <= overrun_set | (overrun   & ~err_clr);
    end
  end

  assign rd_valid = ~fifo_empty;
  assign irq      = rd_valid | frame_err | overrun;

endmodule

// File: tb/tb_uart_rx_bridge.sv
`timescale 1ns/1ps
module tb_uart_rx_bridge;
  import uart_rx_bridge_pkg::*;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             rx;
  logic [DIV_W-1:0] baud_div;
  logic             rd_en;
  logic             err_clr;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             frame_err;
  logic             overrun;
  logic             irq;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [7:0]  exp_q[$];
  logic        exp_ovr = 1'b0;

  always #5 clock = ~clock;

  uart_rx_bridge #(
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .baud_div   (baud_div),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .irq        (irq)
  );

  // Drive one 8N1 frame, one iteration per clock. rd_en or err_clr can be
  // strobed on the cycle whose closing edge is the stop-bit sample (start
  // drive + 2 sync edges + 1 detect edge + half bit + 9 bits).
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int unsigned div, input bit pop_at_stop,
                            input bit clr_at_stop);
    int unsigned eff;
    int unsigned h;
    int unsigned b;
    eff = (div < 4) ? 4 : div;
    h   = eff / 2;
    baud_div = DIV_W'(div);
    for (int unsigned c = 0; c < 10 * eff + 4; c++) begin
      b = c / eff;
      if (b == 0)      rx = 1'b0;
      else if (b <= 8) rx = data[b-1];
      else if (b == 9) rx = stop_bit;
      else             rx = 1'b1;
      rd_en   = pop_at_stop && (c == h + 2 + 9 * eff);
      err_clr = clr_at_stop && (c == h + 2 + 9 * eff);
      @(posedge clock); #1;
    end
    rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    if (stop_bit) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(data);
      else if (pop_at_stop) begin
        void'(exp_q.pop_front());
        exp_q.push_back(data);
      end else exp_ovr = 1'b1;
    end
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clock); #1;
    rd_en = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; baud_div = 16'd16; rd_en = 1'b0; err_clr = 1'b0;
    idle_cycles(3);
    n_vec++;
    if ({rd_data, rd_valid, fifo_count, frame_err, overrun, irq} !== '0) begin
      $display("FAIL reset_outputs: got %h/%b/%0d/%b/%b/%b expected all zero",
               rd_data, rd_valid, fifo_count, frame_err, overrun, irq);
      n_miss++;
    end
    reset = 1'b0;
    idle_cycles(4);
    n_vec++;
    if (dut.state !== RX_IDLE || irq !== 1'b0) begin
      $display("FAIL reset_release: state %0d irq %b expected 0/0", dut.state, irq);
      n_miss++;
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] exp;
    send_frame(8'hA5, 1'b1, 16, 1'b0, 1'b0);
    exp = exp_q[0];
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      $display("FAIL a5_data: got v=%b %h expected v=1 %h", rd_valid, rd_data, exp);
      n_miss++;
    end
    n_vec++;
    if (fifo_count !== 5'd1 || frame_err !== 1'b0 || overrun !== 1'b0 || irq !== 1'b1) begin
      $display("FAIL a5_status: got cnt=%0d fe=%b ov=%b irq=%b expected 1/0/0/1",
               fifo_count, frame_err, overrun, irq);
      n_miss++;
    end
    pop_one(); void'(exp_q.pop_front());
    n_vec++;
    if (fifo_count !== 5'd0 || irq !== 1'b0) begin
      $display("FAIL a5_pop: got cnt=%0d irq=%b expected 0/0", fifo_count, irq);
      n_miss++;
    end
  endtask

  task automatic test_false_start();
    baud_div = 16'd16;
    rx = 1'b0;
    idle_cycles(3);
    rx = 1'b1;
    idle_cycles(40);
    n_vec++;
    if (fifo_count !== 5'd0 || frame_err !== 1'b0 || rd_valid !== 1'b0) begin
      $display("FAIL false_start: got cnt=%0d fe=%b v=%b expected 0/0/0",
               fifo_count, frame_err, rd_valid);
      n_miss++;
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, 16, 1'b0, 1'b0);
    n_vec++;
    if (frame_err !== 1'b1 || fifo_count !== 5'd0 || irq !== 1'b1) begin
      $display("FAIL frame_err_set: got fe=%b cnt=%0d irq=%b expected 1/0/1",
               frame_err, fifo_count, irq);
      n_miss++;
    end
    err_clr = 1'b1; @(posedge clock); #1; err_clr = 1'b0;
    n_vec++;
    if (frame_err !== 1'b0 || irq !== 1'b0) begin
      $display("FAIL frame_err_clr: got fe=%b irq=%b expected 0/0", frame_err, irq);
      n_miss++;
    end
    // New error and clear on the same edge: the error wins.
    send_frame(8'h3C, 1'b0, 8, 1'b0, 1'b1);
    n_vec++;
    if (frame_err !== 1'b1) begin
      $display("FAIL frame_err_vs_clr: got fe=%b expected 1", frame_err);
      n_miss++;
    end
    err_clr = 1'b1; @(posedge clock); #1; err_clr = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int unsigned i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 8, 1'b0, 1'b0);
    n_vec++;
    if (fifo_count !== 5'd16 || overrun !== exp_ovr || overrun !== 1'b1) begin
      $display("FAIL overrun_full: got cnt=%0d ov=%b expected 16/1", fifo_count, overrun);
      n_miss++;
    end
    for (int unsigned i = 0; i < 16; i++) begin
      exp = exp_q.pop_front();
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        $display("FAIL overrun_drain[%0d]: got v=%b %h expected v=1 %h", i, rd_valid, rd_data, exp);
        n_miss++;
      end
      pop_one();
    end
    err_clr = 1'b1; @(posedge clock); #1; err_clr = 1'b0;
    exp_ovr = 1'b0;
    pop_one();
    n_vec++;
    if (fifo_count !== 5'd0 || rd_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      $display("FAIL pop_empty: got cnt=%0d v=%b ov=%b fe=%b expected 0/0/0/0",
               fifo_count, rd_valid, overrun, frame_err);
      n_miss++;
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    for (int unsigned i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, 4, 1'b0, 1'b0);
    send_frame(8'h30, 1'b1, 4, 1'b1, 1'b0);
    n_vec++;
    if (fifo_count !== 5'd16 || overrun !== 1'b0) begin
      $display("FAIL full_push_pop: got cnt=%0d ov=%b expected 16/0", fifo_count, overrun);
      n_miss++;
    end
    for (int unsigned i = 0; i < 16; i++) begin
      exp = exp_q.pop_front();
      n_vec++;
      if (rd_data !== exp) begin
        $display("FAIL full_drain[%0d]: got %h expected %h", i, rd_data, exp);
        n_miss++;
      end
      pop_one();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp;
    send_frame(8'h11, 1'b1, 16, 1'b0, 1'b0);
    // 0x86 has bit 4 clear, so rx is low when reset hits during that bit.
    baud_div = 16'd16;
    for (int unsigned c = 0; c < 5 * 16 + 8; c++) begin
      rx = (c < 16) ? 1'b0 : 8'h86 >> (c / 16 - 1);
      @(posedge clock); #1;
    end
    n_vec++;
    if (dut.state !== RX_DATA) begin
      $display("FAIL mid_frame_state: got %0d expected %0d", dut.state, RX_DATA);
      n_miss++;
    end
    reset = 1'b1; #1;
    exp_q.delete();
    n_vec++;
    if ({rd_data, rd_valid, fifo_count, frame_err, overrun, irq} !== '0 || dut.state !== RX_IDLE) begin
      $display("FAIL mid_frame_reset: got %h/%b/%0d/%b/%b/%b st=%0d expected zeros, IDLE",
               rd_data, rd_valid, fifo_count, frame_err, overrun, irq, dut.state);
      n_miss++;
    end
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(40);
    rx = 1'b1;
    idle_cycles(200);
    n_vec++;
    if (fifo_count !== 5'd0 || frame_err !== 1'b0 || dut.state !== RX_IDLE) begin
      $display("FAIL low_at_release: got cnt=%0d fe=%b st=%0d expected 0/0/IDLE",
               fifo_count, frame_err, dut.state);
      n_miss++;
    end
    send_frame(8'h5A, 1'b1, 4, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      $display("FAIL min_div_5a: got v=%b %h expected v=1 %h", rd_valid, rd_data, exp);
      n_miss++;
    end
    pop_one();
    send_frame(8'hC3, 1'b1, 1, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== exp || fifo_count !== 5'd1) begin
      $display("FAIL clamp_div_c3: got v=%b %h cnt=%0d expected v=1 %h cnt=1",
               rd_valid, rd_data, fifo_count, exp);
      n_miss++;
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    send_frame(8'h01, 1'b1, 5, 1'b0, 1'b0);
    send_frame(8'hFE, 1'b1, 5, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 5, 1'b0, 1'b0);
    n_vec++;
    if (fifo_count !== 5'd3) begin
      $display("FAIL b2b_count: got %0d expected 3", fifo_count);
      n_miss++;
    end
    for (int unsigned i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      n_vec++;
      if (rd_data !== exp) begin
        $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd_data, exp);
        n_miss++;
      end
      pop_one();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_byte();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_full_push_pop();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
